// File: rtl/alu_result_capture.sv
// alu_result_capture: two-entry skid stage capturing ALU results for writeback/branch logic
module alu_result_capture #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_result,
  input  logic          in_zero,
  input  logic [RW-1:0] in_rd,
  input  logic          in_regwrite,
  input  logic          in_branch,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_zero,
  output logic [RW-1:0] out_rd,
  output logic          out_regwrite,
  output logic          branch_taken,
  output logic [CW-1:0] acc_cnt,
  output logic [CW-1:0] zero_cnt
);
  localparam int EW = DW + RW + 3;
  // entry layout: {branch, regwrite, rd, zero, result}
  logic [EW-1:0] ent_in, head_q, head_d, skid_q, skid_d;
  logic          head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d, zero_cnt_q, zero_cnt_d;
  logic          accept, pop, to_skid;
  assign ent_in = {in_branch, in_regwrite, in_rd, in_zero, in_result};
  assign in_ready = !skid_v_q & !flush;
  always_comb begin
    accept = in_valid & in_ready;
    pop = head_v_q & out_ready;
    to_skid = accept & head_v_q & !pop;
    head_d = (skid_v_q & pop) ? skid_q : (accept & (!head_v_q | pop)) ? ent_in : head_q;
    skid_d = to_skid ? ent_in : skid_q;
    head_v_d = !flush & ((head_v_q & !pop) | accept | skid_v_q);
    skid_v_d = !flush & ((skid_v_q & !pop) | to_skid);
    acc_cnt_d = acc_cnt_q + {{(CW-1){1'b0}}, accept};
    zero_cnt_d = zero_cnt_q + {{(CW-1){1'b0}}, accept & in_zero};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      acc_cnt_q <= '0;
      zero_cnt_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      acc_cnt_q <= acc_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end
  assign out_valid = head_v_q;
  assign out_result = head_q[DW-1:0];
  assign out_zero = head_q[DW];
  assign out_rd = head_q[DW+RW:DW+1];
  assign out_regwrite = head_q[DW+RW+1];
  assign branch_taken = head_v_q & head_q[EW-1] & head_q[DW];
  assign acc_cnt = acc_cnt_q;
  assign zero_cnt = zero_cnt_q;
endmodule

// File: tb/tb_alu_result_capture.sv
// tb_alu_result_capture: randomized and directed checks against a queue-based reference model
module tb_alu_result_capture;
  typedef struct packed {
    logic [31:0] r;
    logic        z;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_zero, in_regwrite, in_branch;
  logic        out_valid, out_ready, out_zero, out_regwrite, branch_taken;
  logic [31:0] in_result, out_result;
  logic [4:0]  in_rd, out_rd;
  logic [15:0] acc_cnt, zero_cnt;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  ent_t mq[$];
  int   acc_m, zero_m;

  alu_result_capture dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_zero(in_zero),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_branch(in_branch),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .branch_taken(branch_taken),
    .acc_cnt(acc_cnt), .zero_cnt(zero_cnt)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [31:0] r, input logic z, input logic br);
    ent_t e;
    e.r = r; e.z = z; e.br = br;
    e.rd = 5'($urandom); e.rw = 1'($urandom);
    return e;
  endfunction

  task automatic set_in(input logic v, input ent_t e, input logic ordy, input logic fl);
    in_valid = v; in_result = e.r; in_zero = e.z; in_rd = e.rd;
    in_regwrite = e.rw; in_branch = e.br; out_ready = ordy; flush = fl;
    #1;
  endtask

  // Reference: a FIFO of capacity 2 that refuses input while full or flushing.
  task automatic tick();
    logic acc, pp;
    ent_t e;
    acc = in_valid && mq.size() < 2 && !flush;
    pp = mq.size() > 0 && out_ready;
    e = '{in_result, in_zero, in_rd, in_regwrite, in_branch};
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    if (acc) begin
      acc_m = (acc_m + 1) % 65536;
      if (e.z) zero_m = (zero_m + 1) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    mq.delete(); acc_m = 0; zero_m = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if ({out_result, out_zero, out_rd, out_regwrite, branch_taken} !== 40'd0)
      $display("FAIL reset_out: got %h/%b/%h/%b/%b want zeros", out_result, out_zero, out_rd, out_regwrite, branch_taken); else pass_cnt++;
    total_cnt++; if ({acc_cnt, zero_cnt} !== 32'd0) $display("FAIL reset_cnt: got %h/%h want 0/0", acc_cnt, zero_cnt); else pass_cnt++;
  endtask

  task automatic test_first();
    set_in(1'b1, mk(32'hFFFF_FFF0 + 32'd1, 1'b0, 1'b0), 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_result !== 32'hFFFF_FFF1) $display("FAIL first_result: got %h want fffffff1", out_result); else pass_cnt++;
    total_cnt++; if (acc_cnt !== 16'd1 || zero_cnt !== 16'd0) $display("FAIL first_cnt: got %0d/%0d want 1/0", acc_cnt, zero_cnt); else pass_cnt++;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      a = 32'hFFFF_FFF8 + 32'(i) + 32'd1;
      set_in(i < 8, mk(a, a == 32'd0, 1'b0), 1'b1, 1'b0);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFF8 + 32'(i))
          $display("FAIL stream_out[%0d]: got %b/%h want 1/%h", i, out_valid, out_result, 32'hFFFF_FFF8 + 32'(i)); else pass_cnt++;
      end
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_result !== 32'd0 || out_zero !== 1'b1 || zero_cnt !== 16'd1 || acc_cnt !== 16'd8)
      $display("FAIL stream_last: got %h/%b/%0d/%0d want 0/1/1/8", out_result, out_zero, zero_cnt, acc_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] want_res[5] = '{32'd0, 32'd5, 32'd5, 32'd5, 32'd6};
    logic        want_rdy[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] drv[5] = '{32'd5, 32'd6, 32'd7, 32'd7, 32'd7};
    logic        ordy[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, mk(drv[i], 1'b0, 1'b0), ordy[i], 1'b0);
      total_cnt++; if (in_ready !== want_rdy[i]) $display("FAIL bp_ready[%0d]: got %b want %b", i, in_ready, want_rdy[i]); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (out_valid !== 1'b1 || out_result !== want_res[i])
          $display("FAIL bp_out[%0d]: got %b/%0d want 1/%0d", i, out_valid, out_result, want_res[i]); else pass_cnt++;
      end
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    total_cnt++; if (out_valid !== 1'b1 || out_result !== 32'd7) $display("FAIL bp_last: got %b/%0d want 1/7", out_valid, out_result); else pass_cnt++;
    total_cnt++; if (acc_cnt !== 16'd3) $display("FAIL bp_acc: got %0d want 3", acc_cnt); else pass_cnt++;
    tick();
    set_in(1'b0, '0, 1'b0, 1'b0);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_branch();
    set_in(1'b1, mk(32'd0, 1'b1, 1'b1), 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, i == 2, 1'b0);
      total_cnt++; if (branch_taken !== 1'b1) $display("FAIL br_taken[%0d]: got %b want 1", i, branch_taken); else pass_cnt++;
      tick();
    end
    set_in(1'b1, mk(32'd0, 1'b0, 1'b1), 1'b0, 1'b0);
    total_cnt++; if (branch_taken !== 1'b0) $display("FAIL br_after_pop: got %b want 0", branch_taken); else pass_cnt++;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    total_cnt++; if (out_valid !== 1'b1 || branch_taken !== 1'b0) $display("FAIL br_nz: got %b/%b want 1/0", out_valid, branch_taken); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    int a0, z0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, mk(32'hA000 + 32'(i), 1'b1, 1'b1), 1'b0, 1'b0);
      tick();
    end
    a0 = acc_m; z0 = zero_m;
    set_in(1'b1, mk(32'hBEEF, 1'b1, 1'b0), 1'b0, 1'b1);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_ready_during: got %b want 0", in_ready); else pass_cnt++;
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      total_cnt++; if (out_valid !== 1'b0 || branch_taken !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL flush_after[%0d]: got v%b bt%b r%b want 0/0/1", i, out_valid, branch_taken, in_ready); else pass_cnt++;
      tick();
    end
    total_cnt++; if (int'(acc_cnt) !== a0 || int'(zero_cnt) !== z0)
      $display("FAIL flush_cnt: got %0d/%0d want %0d/%0d", acc_cnt, zero_cnt, a0, z0); else pass_cnt++;
  endtask

  task automatic test_random();
    ent_t h;
    logic fl;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 19) == 0);
      set_in(1'($urandom), mk($urandom_range(0, 3) == 0 ? 32'd0 : $urandom, 1'($urandom), 1'($urandom)),
             $urandom_range(0, 2) != 0, fl);
      total_cnt++; if (in_ready !== (mq.size() < 2 && !fl)) $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, mq.size() < 2 && !fl); else pass_cnt++;
      total_cnt++; if (out_valid !== (mq.size() > 0)) $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, mq.size() > 0); else pass_cnt++;
      if (mq.size() > 0) begin
        h = mq[0];
        total_cnt++; if ({out_result, out_zero, out_rd, out_regwrite, branch_taken} !== {h.r, h.z, h.rd, h.rw, h.br & h.z})
          $display("FAIL rand_head[%0d]: got %h/%b/%h/%b/%b want %h/%b/%h/%b/%b", i, out_result, out_zero, out_rd, out_regwrite,
                   branch_taken, h.r, h.z, h.rd, h.rw, h.br & h.z); else pass_cnt++;
      end else begin
        total_cnt++; if (branch_taken !== 1'b0) $display("FAIL rand_bt_empty[%0d]: got %b want 0", i, branch_taken); else pass_cnt++;
      end
      total_cnt++; if (int'(acc_cnt) !== acc_m || int'(zero_cnt) !== zero_m)
        $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, acc_cnt, zero_cnt, acc_m, zero_m); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      set_in(1'b1, mk(32'd1, 1'b0, 1'b0), 1'b1, 1'b0);
      tick();
    end
    set_in(1'b1, mk(32'd1, 1'b0, 1'b0), 1'b1, 1'b0);
    total_cnt++; if (acc_cnt !== 16'hFFFF) $display("FAIL wrap_pre: got %h want ffff", acc_cnt); else pass_cnt++;
    tick();
    set_in(1'b1, mk(32'd2, 1'b0, 1'b0), 1'b1, 1'b0);
    total_cnt++; if (acc_cnt !== 16'h0000 || int'(acc_cnt) !== acc_m) $display("FAIL wrap_post: got %h want 0000", acc_cnt); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL async_pre: got %b want 1", out_valid); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || branch_taken !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL async_rst: got v%b bt%b r%b want 0/0/1", out_valid, branch_taken, in_ready); else pass_cnt++;
    mq.delete(); acc_m = 0; zero_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first();
    test_stream();
    test_backpressure();
    test_branch();
    test_flush();
    test_random();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Receive-side stage for the ALU output interface (Result, zero): registers each ALU result and its writeback/branch tags, and presents them to the writeback/branch logic.
- valid/ready handshake on both sides; a 2-entry skid buffer keeps ALU throughput at one result per cycle while writeback stalls.
- Derives branch_taken from the captured zero flag.
- Keeps a wrapping count of accepted results and of zero results for bench and debug use.

Parameters:
- DW, 32, data width of ALU result.
- RW, 5, register-address width (destination rd).
- CW, 16, width of the accept and zero-result counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept.
- in_result  input  DW  ALU Result.
- in_zero  input  1  ALU zero flag.
- in_rd  input  RW  destination register.
- in_regwrite  input  1  result is to be written back.
- in_branch  input  1  instruction is a beq-type branch.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_result  output  DW  head result.
- out_zero  output  1  head zero flag.
- out_rd  output  RW  head destination.
- out_regwrite  output  1  head regwrite.
- branch_taken  output  1  out_valid & head branch & head zero.
- acc_cnt  output  CW  accepted-result count.
- zero_cnt  output  CW  accepted results with zero=1.

Behaviour:
- Storage:
  - head register (drives out_*) and skid register, each with its own valid bit.
  - Occupancy is 0, 1 (head only) or 2 (head+skid).
  - The skid is never valid while the head is empty.
- Reset (rst=1, async):
  - both valid bits 0; out_valid=0; out_result=0, out_zero=0, out_rd=0, out_regwrite=0, branch_taken=0.
  - acc_cnt=0, zero_cnt=0; in_ready=1.
- in_ready = !skid_valid & !flush. Depends on registered state and flush only; no combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the same edge.
- Latency: an accepted result appears on out_* in the next cycle if the head is empty, or if the head pops in the same cycle with the skid empty.
- Transitions:
  - occ0: accept -> occ1 (data to head).
  - occ1:
    - accept & pop -> occ1, head gets the new data.
    - accept & !pop -> occ2, data to skid.
    - pop & !accept -> occ0.
    - neither -> hold.
  - occ2: accept is impossible (in_ready=0).
    - pop -> occ1, skid moves to head.
    - !pop -> hold; out_* stable.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- out_* must remain stable while out_valid=1 and out_ready=0.
- Flush:
  - next edge clears both valid bits; in_ready=0 during the flush cycle.
  - Any in_valid in that cycle is dropped and not counted.
  - Data registers may retain stale values, but out_valid=0 and branch_taken=0.
- Counters:
  - acc_cnt increments on each accept; zero_cnt increments on each accept with in_zero=1.
  - Both wrap modulo 2^CW and are cleared only by rst (not by flush).
- branch_taken is combinational from head registers only; it is 0 whenever out_valid=0.
- Reset mid-operation discards all entries immediately (async).

Test Plan:
- Reset, then in_valid=1 with in_result=32'hFFFF_FFF0+1, in_zero=0, out_ready=1 -> next cycle out_valid=1, out_result=32'hFFFF_FFF1, acc_cnt=1, zero_cnt=0.
- Stream 8 results (A=32'hFFFF_FFF8..32'hFFFF_FFFF, +1 each) with out_ready=1 -> in_ready stays 1, outputs in order one per cycle, final result 32'h0000_0000 with out_zero=1, zero_cnt=1.
- Hold out_ready=0, push 3 results (5, 6, 7) -> 5 in head, 6 in skid, in_ready=0 on third attempt, 7 not accepted; release out_ready -> outputs 5, 6, then 7 after it is re-presented; acc_cnt=3.
- Branch: in_branch=1, in_zero=1, in_result=0 accepted -> branch_taken=1 exactly while that entry is head; same entry with in_zero=0 -> branch_taken=0.
- Occupancy 2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged, flushed data never appears.
- Preload acc_cnt to 16'hFFFF via 65535 accepts, one more accept -> acc_cnt=0; assert rst asynchronously mid-stream -> out_valid drops before next clock edge.
